// File: rtl/otter_cu_fsm.sv
// Multi-cycle control FSM for the OTTER RV32I core.
// Sequences INIT/FETCH/EXEC/WB/INTR and drives the PC, RF, memory and CSR strobes.
module otter_cu_fsm #(
   parameter int INIT_CYCLES = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [6:0] ir6_0,
   input  logic [2:0] ir14_12,
   input  logic       intr,
   input  logic       mie,
   output logic       PCWrite,
   output logic       regWrite,
   output logic       memWE2,
   output logic       memRDEN1,
   output logic       memRDEN2,
   output logic       reset,
   output logic       csr_WE,
   output logic       int_taken,
   output logic       mret_exec
);

   localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYS    = 7'b1110011;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WB    = 3'd3,
      ST_INTR  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             take_intr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // A request seen on the INTR cycle itself must survive into the next boundary.
   assign pend_d    = intr | (pend_q & (state_q != ST_INTR));
   assign take_intr = (pend_q | intr) & mie;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      PCWrite   = 1'b0;
      regWrite  = 1'b0;
      memWE2    = 1'b0;
      memRDEN1  = 1'b0;
      memRDEN2  = 1'b0;
      reset     = 1'b0;
      csr_WE    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;

      unique case (state_q)
         ST_INIT: begin
            reset = 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_FETCH;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_FETCH: begin
            memRDEN1 = 1'b1;
            state_d  = ST_EXEC;
         end

         ST_EXEC: begin
            state_d = take_intr ? ST_INTR : ST_FETCH;
            unique case (ir6_0)
               OP_LOAD: begin
                  memRDEN2 = 1'b1;
                  state_d  = ST_WB;
               end
               OP_STORE: begin
                  memWE2  = 1'b1;
                  PCWrite = 1'b1;
               end
               OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                  PCWrite  = 1'b1;
                  regWrite = 1'b1;
               end
               OP_SYS: begin
                  PCWrite = 1'b1;
                  if (ir14_12 == 3'b001) begin
                     csr_WE   = 1'b1;
                     regWrite = 1'b1;
                  end else if (ir14_12 == 3'b000) begin
                     mret_exec = 1'b1;
                  end
               end
               default: PCWrite = 1'b1;
            endcase
         end

         ST_WB: begin
            regWrite = 1'b1;
            PCWrite  = 1'b1;
            state_d  = take_intr ? ST_INTR : ST_FETCH;
         end

         ST_INTR: begin
            int_taken = 1'b1;
            PCWrite   = 1'b1;
            state_d   = ST_FETCH;
         end

         default: state_d = ST_INIT;
      endcase
   end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm: each cycle pushes the expected strobe vector
// and pops it for comparison at the following falling edge.
module tb_otter_cu_fsm;

   logic       CLK = 1'b0;
   logic       RST;
   logic [6:0] ir6_0;
   logic [2:0] ir14_12;
   logic       intr;
   logic       mie;
   logic       PCWrite, regWrite, memWE2, memRDEN1, memRDEN2;
   logic       reset, csr_WE, int_taken, mret_exec;

   otter_cu_fsm #(.INIT_CYCLES(1)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .ir6_0    (ir6_0),
      .ir14_12  (ir14_12),
      .intr     (intr),
      .mie      (mie),
      .PCWrite  (PCWrite),
      .regWrite (regWrite),
      .memWE2   (memWE2),
      .memRDEN1 (memRDEN1),
      .memRDEN2 (memRDEN2),
      .reset    (reset),
      .csr_WE   (csr_WE),
      .int_taken(int_taken),
      .mret_exec(mret_exec)
   );

   always #5 CLK = ~CLK;

   // {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec}
   localparam logic [8:0] O_INIT  = 9'b000001000;
   localparam logic [8:0] O_FETCH = 9'b000100000;
   localparam logic [8:0] O_ALU   = 9'b110000000;
   localparam logic [8:0] O_LOAD  = 9'b000010000;
   localparam logic [8:0] O_WB    = 9'b110000000;
   localparam logic [8:0] O_STORE = 9'b101000000;
   localparam logic [8:0] O_PCW   = 9'b100000000;
   localparam logic [8:0] O_CSRRW = 9'b110000100;
   localparam logic [8:0] O_MRET  = 9'b100000001;
   localparam logic [8:0] O_INTR  = 9'b100000010;

   localparam logic [6:0] LD  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] ADI = 7'b0010011;
   localparam logic [6:0] LUI = 7'b0110111;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] SYS = 7'b1110011;
   localparam logic [6:0] FEN = 7'b0001111;

   typedef struct {
      logic [8:0] vec;
      string      tag;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   function automatic logic [8:0] observed();
      return {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
              reset, csr_WE, int_taken, mret_exec};
   endfunction

   // One clock cycle: drive inputs (sampled at the closing edge), check outputs mid-cycle.
   task automatic cyc(input logic r, input logic [6:0] op, input logic [2:0] f3,
                      input logic irq, input logic en, input logic chk,
                      input logic [8:0] exp_vec, input string tag);
      exp_t e;
      logic [8:0] obs;
      RST     = r;
      ir6_0   = op;
      ir14_12 = f3;
      intr    = irq;
      mie     = en;
      if (chk) begin
         e.vec = exp_vec;
         e.tag = tag;
         sb_q.push_back(e);
      end
      @(negedge CLK);
      if (chk) begin
         e   = sb_q.pop_front();
         obs = observed();
         tests++;
         assert (obs === e.vec) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.vec);
         end
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // reset held two cycles, then one INIT cycle
      cyc(1, 0, 0, 0, 0, 0, O_INIT, "pre_reset");
      cyc(1, 0, 0, 0, 0, 1, O_INIT, "rst_hold");
      cyc(0, 0, 0, 0, 1, 1, O_INIT, "init");
      // addi
      cyc(0, 0,   0, 0, 1, 1, O_FETCH, "fetch_addi");
      cyc(0, ADI, 0, 0, 1, 1, O_ALU,   "exec_addi");
      // lw: three cycles
      cyc(0, 0,  0, 0, 1, 1, O_FETCH, "fetch_lw");
      cyc(0, LD, 0, 0, 1, 1, O_LOAD,  "exec_lw");
      cyc(0, LD, 0, 0, 1, 1, O_WB,    "wb_lw");
      // intr pulse during FETCH of sw
      cyc(0, 0,  0, 1, 1, 1, O_FETCH, "fetch_sw_irq");
      cyc(0, SW, 0, 0, 1, 1, O_STORE, "exec_sw");
      cyc(0, 0,  0, 0, 1, 1, O_INTR,  "intr_after_sw");
      cyc(0, 0,   0, 0, 1, 1, O_FETCH, "fetch_pend_clr");
      cyc(0, ADI, 0, 0, 1, 1, O_ALU,   "exec_pend_clr");
      // intr held with mie=0 across three instructions
      cyc(0, 0,   0, 1, 0, 1, O_FETCH, "mask_fetch1");
      cyc(0, LUI, 0, 1, 0, 1, O_ALU,   "mask_lui");
      cyc(0, 0,   0, 1, 0, 1, O_FETCH, "mask_fetch2");
      cyc(0, BR,  0, 1, 0, 1, O_PCW,   "mask_branch");
      cyc(0, 0,   0, 1, 0, 1, O_FETCH, "mask_fetch3");
      cyc(0, LD,  0, 1, 0, 1, O_LOAD,  "mask_lw");
      cyc(0, LD,  0, 1, 0, 1, O_WB,    "mask_wb");
      // enable: taken after next instruction
      cyc(0, 0,   0,      0, 1, 1, O_FETCH, "unmask_fetch");
      cyc(0, SYS, 3'b001, 0, 1, 1, O_CSRRW, "exec_csrrw");
      cyc(0, 0,   0,      0, 1, 1, O_INTR,  "intr_after_csrrw");
      // mret with intr but mie currently 0: no take
      cyc(0, 0,   0,      0, 0, 1, O_FETCH, "fetch_mret");
      cyc(0, SYS, 3'b000, 1, 0, 1, O_MRET,  "exec_mret");
      cyc(0, 0,   0,      0, 1, 1, O_FETCH, "fetch_after_mret");
      cyc(0, FEN, 0,      0, 1, 1, O_PCW,   "exec_fence_nop");
      // intr on the INTR cycle itself keeps the request pending
      cyc(0, 0,   0, 1, 1, 1, O_INTR,  "intr_set_wins");
      cyc(0, 0,   0, 0, 1, 1, O_FETCH, "fetch_jal");
      cyc(0, JAL, 0, 0, 1, 1, O_ALU,   "exec_jal");
      cyc(0, 0,   0, 0, 1, 1, O_INTR,  "intr_repend");
      // unknown SYSTEM funct3 acts as NOP; intr during load waits for WB
      cyc(0, 0,   0,      0, 1, 1, O_FETCH, "fetch_sysnop");
      cyc(0, SYS, 3'b010, 0, 1, 1, O_PCW,   "exec_sysnop");
      cyc(0, 0,   0, 1, 1, 1, O_FETCH, "fetch_lw_irq");
      cyc(0, LD,  0, 0, 1, 1, O_LOAD,  "exec_lw_irq");
      cyc(0, LD,  0, 0, 1, 1, O_WB,    "wb_lw_irq");
      cyc(0, 0,   0, 0, 1, 1, O_INTR,  "intr_after_wb");
      // reset during EXEC of sw with pending intr
      cyc(0, 0,   0, 1, 0, 1, O_FETCH, "fetch_sw_rst");
      cyc(1, SW,  0, 0, 1, 1, O_STORE, "exec_sw_rst");
      cyc(0, SW,  0, 0, 1, 1, O_INIT,  "init_after_rst");
      cyc(0, 0,   0, 0, 1, 1, O_FETCH, "fetch_post_rst");
      cyc(0, ADI, 0, 0, 1, 1, O_ALU,   "exec_post_rst");
      cyc(0, 0,   0, 0, 1, 1, O_FETCH, "pend_cleared_by_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
